// File: rtl/obf_pkg.sv
// Shared types and elaboration-time helpers for the obfuscated SECDED pipeline.
//   key_state_e : key loader FSM states
//   chk_w()     : number of Hamming check bits for a given data width
//   data_pos()  : codeword position (1-based) of data bit idx
package obf_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StLoading,
        StArmed
    } key_state_e;

    // Smallest r with 2^r >= data_w + r + 1. Scanning downwards leaves the smallest hit.
    function automatic int unsigned chk_w(input int unsigned data_w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 7; i >= 1; i--) begin
            if ((32'd1 << i) >= data_w + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/obf_secded_pipe_if.sv
// Input/output handshake bundle of obf_secded_pipe.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : pipeline side (drives in_ready, out_*)
interface obf_secded_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    import obf_pkg::*;

    localparam int unsigned CHK_W = chk_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W:0]    in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err_single;
    logic              out_err_double;

    modport master (
        output in_valid, in_data, in_chk, out_ready,
        input  in_ready, out_valid, out_data, out_err_single, out_err_double
    );

    modport slave (
        input  in_valid, in_data, in_chk, out_ready,
        output in_ready, out_valid, out_data, out_err_single, out_err_double
    );

endinterface

// File: rtl/obf_key_loader.sv
// Serial key loader. Bits arrive LSB first into a shadow register; the KEY_W-th beat
// commits the shadow to the active key. A reload from ARMED keeps the old key live
// until its own commit. key_clr aborts everything and zeroes the active key.
//   clk, rst_n  : clock, async active-low reset
//   key_bit     : serial key bit, qualified by key_valid
//   key_clr     : abort load, zero key (beats key_valid)
//   key_active  : committed key
//   key_loaded  : a full key has been committed since the last clear/reset
module obf_key_loader #(
    parameter int unsigned KEY_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_bit,
    input  logic             key_valid,
    input  logic             key_clr,
    output logic [KEY_W-1:0] key_active,
    output logic             key_loaded
);
    import obf_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W - 1);

    key_state_e       state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loaded_q, loaded_d;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (key_clr) begin
            state_d  = StEmpty;
            shadow_d = '0;
            key_d    = '0;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else if (key_valid) begin
            shadow_d = {key_bit, shadow_q[KEY_W-1:1]};
            if (cnt_q == LAST_CNT) begin
                // Final beat: commit including the bit arriving now.
                key_d    = shadow_d;
                state_d  = StArmed;
                loaded_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StLoading;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign key_active = key_q;
    assign key_loaded = loaded_q;

endmodule

// File: rtl/obf_secded_pipe.sv
// Two-stage extended-Hamming (SECDED) decoder whose output is masked by a serially
// loaded key: out_data = corrected ^ key ^ KEY_POL, so only the right key yields
// the plain data. Stage 1 registers data, syndrome, parity mismatch and a key
// snapshot; stage 2 registers the corrected, masked word and error flags.
//   clk, rst_n           : clock, async active-low reset
//   key_bit/valid/clr    : serial key load port (see obf_key_loader)
//   key_loaded           : full key committed
//   bus (slave)          : in_valid/in_ready/in_data/in_chk, out_valid/out_ready/
//                          out_data/out_err_single/out_err_double
module obf_secded_pipe #(
    parameter int unsigned      DATA_W  = 32,
    parameter int unsigned      KEY_W   = 16,
    parameter logic [KEY_W-1:0] KEY_POL = 16'h3AE4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_bit,
    input  logic              key_valid,
    input  logic              key_clr,
    output logic              key_loaded,
    obf_secded_pipe_if.slave  bus
);
    import obf_pkg::*;

    localparam int unsigned CHK_W  = chk_w(DATA_W);
    localparam int unsigned CODE_N = DATA_W + CHK_W;
    localparam int unsigned REPS   = DATA_W / KEY_W;

    typedef logic [DATA_W-1:0][CHK_W-1:0] pos_tbl_t;
    typedef logic [CHK_W-1:0][DATA_W-1:0] mask_tbl_t;

    function automatic pos_tbl_t build_pos();
        pos_tbl_t t;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            t[i] = CHK_W'(data_pos(i));
        end
        return t;
    endfunction

    // Mask j selects the data bits whose codeword position has bit j set.
    function automatic mask_tbl_t build_masks();
        mask_tbl_t m;
        for (int unsigned j = 0; j < CHK_W; j++) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                m[j][i] = ((data_pos(i) >> j) & 32'd1) != 32'd0;
            end
        end
        return m;
    endfunction

    localparam pos_tbl_t  DATA_POS = build_pos();
    localparam mask_tbl_t SYN_MASK = build_masks();

    logic [KEY_W-1:0] key_active;

    obf_key_loader #(
        .KEY_W (KEY_W)
    ) u_key (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_clr    (key_clr),
        .key_active (key_active),
        .key_loaded (key_loaded)
    );

    // Pipeline state
    logic              init_q;
    logic              s1_valid_q, s2_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [CHK_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic [KEY_W-1:0]  s1_key_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_single_q, s2_double_q;

    logic              s1_adv, s2_adv, accept;
    logic [CHK_W-1:0]  syn_d;
    logic              par_d;
    logic [DATA_W-1:0] corr;
    logic [DATA_W-1:0] out_d;
    logic              single_d, double_d;

    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    // init_q holds in_ready low until the first edge after reset release.
    assign bus.in_ready = init_q && s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        syn_d = '0;
        for (int unsigned j = 0; j < CHK_W; j++) begin
            syn_d[j] = ^(bus.in_data & SYN_MASK[j]) ^ bus.in_chk[j+1];
        end
        par_d = ^{bus.in_data, bus.in_chk};
    end

    always_comb begin
        corr     = s1_data_q;
        single_d = 1'b0;
        double_d = 1'b0;
        if (s1_syn_q == '0) begin
            single_d = s1_par_q;
        end else if (32'(s1_syn_q) > CODE_N || !s1_par_q) begin
            double_d = 1'b1;
        end else begin
            single_d = 1'b1;
            // No match means the error sits on a check bit: data stays as is.
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (s1_syn_q == DATA_POS[i]) begin
                    corr[i] = ~s1_data_q[i];
                end
            end
        end
        out_d = corr ^ {REPS{s1_key_q ^ KEY_POL}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_key_q    <= '0;
            s2_data_q   <= '0;
            s2_single_q <= 1'b0;
            s2_double_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= bus.in_data;
                    s1_syn_q  <= syn_d;
                    s1_par_q  <= par_d;
                    s1_key_q  <= key_active;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q   <= out_d;
                    s2_single_q <= single_d;
                    s2_double_q <= double_d;
                end
            end
        end
    end

    assign bus.out_valid      = s2_valid_q;
    assign bus.out_data       = s2_data_q;
    assign bus.out_err_single = s2_single_q;
    assign bus.out_err_double = s2_double_q;

endmodule
